fifo_rd_ctrl: RTL

FIFO_RD_CTRL -- requirements
Module: fifo_rd_ctrl

---
 rtl/fifo_rd_ctrl.sv | 99 +++++++++
 1 files changed

// File: rtl/fifo_rd_ctrl.sv
// Read side of an asynchronous FIFO: synchronises the write pointer, issues
// memory reads and presents the returned words through a 2-entry output buffer.
module fifo_rd_ctrl #(
  parameter int  DATASIZE = 8,
  parameter int  DEPTH    = 8,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic                rclk,
  input  logic                rrst,
  input  logic [AW:0]         wptr_gray,
  output logic                ren,
  output logic [AW-1:0]       raddr,
  input  logic [DATASIZE-1:0] rdata,
  output logic [AW:0]         rptr_gray,
  output logic                rempty,
  output logic [AW:0]         rcount,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [DATASIZE-1:0] m_data
);

  function automatic logic [AW:0] gray2bin(input logic [AW:0] g);
    logic [AW:0] b;
    b[AW] = g[AW];
    for (int i = AW - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  logic [AW:0]         wq1, wq2, wbin_s;
  logic [AW:0]         rbin, rbin_next;
  logic [1:0]          buf_cnt;
  logic                inflight;
  logic [DATASIZE-1:0] buf0, buf1;
  logic                pop;
  logic [2:0]          slots;

  // NOTE: every clocked process uses non-blocking assignments so all flops
  // sample pre-edge values, regardless of process ordering in simulation.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      wq1 <= '0;
      wq2 <= '0;
    end else begin
      wq1 <= wptr_gray;
      wq2 <= wq1;
    end
  end

  assign wbin_s    = gray2bin(wq2);
  assign rempty    = (rbin == wbin_s);
  assign rcount    = wbin_s - rbin;
  assign raddr     = rbin[AW-1:0];
  assign rbin_next = rbin + {{AW{1'b0}}, ren};

  assign m_valid = (buf_cnt != 2'd0);
  assign m_data  = buf0;
  assign pop     = m_valid & m_ready;

  // Words already owned (buffered or in flight) once this cycle's pop leaves;
  // a new read is only issued if its word is guaranteed a buffer slot.
  assign slots = {1'b0, buf_cnt} + {2'b00, inflight} - {2'b00, pop};
  assign ren   = !rrst && !rempty && (slots < 3'd2);

  always_ff @(posedge rclk) begin
    if (rrst) begin
      rbin      <= '0;
      rptr_gray <= '0;
      inflight  <= 1'b0;
    end else begin
      rbin      <= rbin_next;
      rptr_gray <= rbin_next ^ (rbin_next >> 1);
      inflight  <= ren;
    end
  end

  // buf0 is always the oldest word; buf1 only ever holds the second one.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      buf_cnt <= 2'd0;
      buf0    <= '0;
    end else begin
      buf_cnt <= buf_cnt + {1'b0, inflight} - {1'b0, pop};
      if (pop) begin
        buf0 <= (inflight && buf_cnt == 2'd1) ? rdata : buf1;
      end else if (inflight && buf_cnt == 2'd0) begin
        buf0 <= rdata;
      end
    end
  end

  // NOTE: buf1 is pure storage qualified by buf_cnt, so it carries no reset;
  // a stale value there is never observable.
  always_ff @(posedge rclk) begin
    if (inflight && ((pop && buf_cnt == 2'd2) || (!pop && buf_cnt == 2'd1))) begin
      buf1 <= rdata;
    end
  end

endmodule
